// File: rtl/hd_elastic_fifo.sv
// ============================================================================
// hd_elastic_fifo
// ----------------------------------------------------------------------------
// Purpose:
//   Elastic valid/ready buffer holding up to DEPTH words in a circular store.
//   It accepts one word per cycle from upstream and presents one word per
//   cycle to downstream. Both flow-control outputs are decoded from the
//   registered occupancy only, so the block breaks every combinational path
//   between its two sides. It reports its occupancy and supports a
//   synchronous flush.
//
// Parameters:
//   DATA_WIDTH  payload width in bits (>= 1)
//   DEPTH       number of entries (power of two, >= 2)
//   AW / CW     derived pointer width and occupancy-count width
//
// Ports:
//   clk           in   clock; all state changes on the rising edge
//   rst           in   asynchronous, active-high reset
//   valid         in   upstream offers data_src this cycle
//   data_src      in   upstream payload
//   ready_output  out  block can accept a word this cycle
//   valid_output  out  data_dest holds a valid word for downstream
//   data_dest     out  head-of-buffer payload (0 while empty)
//   ready         in   downstream accepts the word on valid_output
//   flush         in   synchronous discard of every stored word
//   high_water    out  highest occupancy reached since reset
//                      (present only when HD_FIFO_HIGH_WATER_EN is defined)
//   count         out  current occupancy, 0..DEPTH
//
// Optional feature macro:
//   HD_FIFO_HIGH_WATER_EN  adds the high_water output and its register.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where the sender's valid and the
//   receiver's ready are both 1. After valid is raised, the sender holds it
//   and its payload stable until that transfer has happened. On the output
//   side this block keeps valid_output and data_dest stable while
//   valid_output = 1 and ready = 0. The ready input may toggle freely.
// ============================================================================
module hd_elastic_fifo #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data_src,
    output logic                  ready_output,
    output logic                  valid_output,
    output logic [DATA_WIDTH-1:0] data_dest,
    input  logic                  ready,
    input  logic                  flush,
`ifdef HD_FIFO_HIGH_WATER_EN
    output logic [CW-1:0]         high_water,
`endif
    output logic [CW-1:0]         count
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    // ------------------------------------------------------------------------
    // Status decode (registered count only)
    // ------------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_store;
    logic [CW-1:0] w_count_next;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // ready_output drops while rst is high so that upstream never believes a
    // word was taken during reset.
    assign ready_output = !w_full && !rst;
    assign valid_output = !w_empty;

    assign w_push = valid && ready_output;
    assign w_pop  = valid_output && ready;

    // A flush still completes the upstream handshake; the word is just not
    // written, so the store enable excludes flush.
    assign w_store = w_push && !flush;

    // ------------------------------------------------------------------------
    // Next occupancy. Flush wins over any push or pop in the same cycle.
    // Full and empty are told apart by count, never by pointer compare.
    // ------------------------------------------------------------------------
    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CW'(1);
                2'b01:   w_count_next = r_count - CW'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Pointers and occupancy. DEPTH is a power of two, so pointer increment
    // wraps DEPTH-1 -> 0 by plain overflow.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

    // ------------------------------------------------------------------------
    // Storage: intentionally not reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= data_src;
        end
    end

    // Head word is gated by occupancy. The gate gives data_dest = 0 in reset
    // and while empty, and it hides the unreset storage contents. While
    // valid_output is 1 the gate is open and the head word is stable.
    assign data_dest = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;

`ifdef HD_FIFO_HIGH_WATER_EN
    // ------------------------------------------------------------------------
    // High-water mark. This tracks the next occupancy, so a flush (next
    // count 0) can never lower it. Only reset clears it.
    // ------------------------------------------------------------------------
    logic [CW-1:0] r_high_water;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_high_water <= '0;
        end else if (w_count_next > r_high_water) begin
            r_high_water <= w_count_next;
        end
    end

    assign high_water = r_high_water;
`endif

endmodule
